// File: rtl/stream_mux_rr.sv
// stream_mux_rr
// Registered N:1 stream multiplexer with valid/ready handshakes. It has two
// modes. In select mode (mode=0) the channel named by sel is forwarded. In
// round-robin mode (mode=1) requesters are arbitrated fairly, starting the
// search one past the last channel that won.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   mode         0 = select, 1 = round-robin
//   sel          channel index for select mode
//   in_valid     per-channel valid, bit i = channel i
//   in_data      channel i at [i*DATA_W +: DATA_W]
//   in_ready     per-channel ready (one-hot or zero)
//   out_valid    output register holds a beat
//   out_data     registered beat
//   out_ch       channel that supplied out_data
//   out_ready    consumer accepts the beat
module stream_mux_rr #(
   parameter  int NUM_CH = 4,
   parameter  int DATA_W = 8,
   localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     mode,
   input  logic [SEL_W-1:0]         sel,
   input  logic [NUM_CH-1:0]        in_valid,
   input  logic [NUM_CH*DATA_W-1:0] in_data,
   output logic [NUM_CH-1:0]        in_ready,
   output logic                     out_valid,
   output logic [DATA_W-1:0]        out_data,
   output logic [SEL_W-1:0]         out_ch,
   input  logic                     out_ready
);

   logic              load_en;
   logic [SEL_W-1:0]  rr_ptr;
   logic [NUM_CH-1:0] grant;
   logic              gnt_any;
   logic [SEL_W-1:0]  gnt_idx;
   logic [DATA_W-1:0] gnt_data;
   int                best_d;
   int                d;

   // Output register can take a beat when empty or drained this cycle.
   assign load_en = !out_valid || out_ready;

   // Grant selection. In round-robin mode each channel's priority is its
   // distance past rr_ptr. Distance 0 is rr_ptr+1, so the last winner ranks
   // lowest. The valid channel with the smallest distance wins.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      best_d  = NUM_CH;
      d       = 0;
      if (!mode) begin
         // Comparing against each legal index means an out-of-range sel
         // (non power-of-two NUM_CH) simply matches nothing.
         for (int i = 0; i < NUM_CH; i++) begin
            if (sel == SEL_W'(i) && in_valid[i]) begin
               gnt_any = 1'b1;
               gnt_idx = SEL_W'(i);
            end
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            d = (i - int'(rr_ptr) - 1 + 2 * NUM_CH) % NUM_CH;
            if (in_valid[i] && d < best_d) begin
               best_d  = d;
               gnt_any = 1'b1;
               gnt_idx = SEL_W'(i);
            end
         end
      end
   end

   always_comb begin
      grant    = '0;
      gnt_data = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         grant[i] = gnt_any && (gnt_idx == SEL_W'(i));
         if (grant[i]) gnt_data = in_data[i*DATA_W +: DATA_W];
      end
   end

   // in_ready is gated with rst_n so that no handshake is offered while the
   // block is held in reset. out_valid is 0 then, so load_en alone would be 1.
   assign in_ready = (rst_n && load_en) ? grant : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         rr_ptr    <= SEL_W'(NUM_CH - 1);
      end else if (load_en) begin
         out_valid <= gnt_any;
         if (gnt_any) begin
            out_data <= gnt_data;
            out_ch   <= gnt_idx;
            // Pointer only tracks round-robin winners.
            if (mode) rr_ptr <= gnt_idx;
         end
      end
   end

endmodule

// File: tb/tb_stream_mux_rr.sv
module tb_stream_mux_rr;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mode;
   logic [1:0]  sel;
   logic [3:0]  in_valid;
   logic [7:0]  d [4];
   logic [31:0] in_data;
   logic [3:0]  in_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic [1:0]  out_ch;
   logic        out_ready;

   // three-channel build
   logic        mode3;
   logic [1:0]  sel3;
   logic [2:0]  in_valid3;
   logic [23:0] in_data3;
   logic [2:0]  in_ready3;
   logic        out_valid3;
   logic [7:0]  out_data3;
   logic [1:0]  out_ch3;
   logic        out_ready3;

   int total = 0;
   int bad   = 0;

   // reference model state
   logic       m_valid;
   logic [7:0] m_data;
   logic [1:0] m_ch;
   int         m_ptr;

   assign in_data = {d[3], d[2], d[1], d[0]};

   always #5 clk = ~clk;

   stream_mux_rr #(.NUM_CH(4), .DATA_W(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
      .out_ready(out_ready)
   );

   stream_mux_rr #(.NUM_CH(3), .DATA_W(8)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
      .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
      .out_valid(out_valid3), .out_data(out_data3), .out_ch(out_ch3),
      .out_ready(out_ready3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Winner by the plain rules: sel in select mode, otherwise the first
   // valid channel walking ptr+1, ptr+2, ... modulo 4. -1 means no grant.
   function automatic int exp_grant(logic md, logic [1:0] s, logic [3:0] v, int ptr);
      int c;
      if (!md) return v[s] ? int'(s) : -1;
      for (int k = 1; k <= 4; k++) begin
         c = (ptr + k) % 4;
         if (v[c[1:0]]) return c;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_valid = 1'b0;
      m_data  = 8'h00;
      m_ch    = 2'd0;
      m_ptr   = 3;
   endtask

   // Inputs are already applied. Check at the falling edge, then advance
   // the model at the rising edge.
   task automatic cycle();
      int         g;
      logic [3:0] er;
      logic       ld;
      @(negedge clk);
      g  = exp_grant(mode, sel, in_valid, m_ptr);
      ld = !m_valid || out_ready;
      er = 4'b0000;
      if (ld && g >= 0) er[g[1:0]] = 1'b1;
      chk("in_ready", 32'(in_ready), 32'(er));
      chk("out", 32'({out_valid, out_ch, out_data}), 32'({m_valid, m_ch, m_data}));
      @(posedge clk);
      if (ld) begin
         m_valid = (g >= 0);
         if (g >= 0) begin
            m_data = d[g];
            m_ch   = g[1:0];
            if (mode) m_ptr = g;
         end
      end
      #1;
   endtask

   initial begin
      rst_n = 1'b0; mode = 1'b1; sel = 2'd0; in_valid = 4'hf; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) d[i] = 8'h00;
      mode3 = 1'b0; sel3 = 2'd0; in_valid3 = 3'b000; in_data3 = 24'h0; out_ready3 = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out", 32'({out_valid, out_ch, out_data}), 32'h0);
      chk("rst_in_ready", 32'(in_ready), 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // select mode, channel 2
      mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; d[2] = 8'hA5;
      cycle();
      in_valid = 4'b0000;
      cycle();
      // selected channel idle
      sel = 2'd1; in_valid = 4'b1101;
      cycle();
      cycle();

      // round-robin, all channels requesting
      mode = 1'b1; in_valid = 4'hf;
      for (int i = 0; i < 4; i++) d[i] = 8'h10 + 8'(i);
      repeat (6) cycle();
      // stall with a beat held
      out_ready = 1'b0;
      repeat (3) cycle();
      out_ready = 1'b1;
      repeat (2) cycle();
      // wrap: ch3 wins, then ch0 beats ch3
      in_valid = 4'b1000;
      cycle();
      in_valid = 4'b1001;
      cycle();
      cycle();

      // reset with a beat held
      in_valid = 4'hf;
      cycle();
      rst_n = 1'b0;
      #1;
      chk("midrst_out", 32'({out_valid, out_ch, out_data}), 32'h0);
      chk("midrst_in_ready", 32'(in_ready), 32'h0);
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      cycle();
      cycle();

      // random traffic
      for (int n = 0; n < 400; n++) begin
         mode      = 1'($urandom_range(0, 3) != 0);
         sel       = 2'($urandom);
         in_valid  = 4'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
         cycle();
      end
      out_ready = 1'b1; in_valid = 4'h0;
      cycle();

      // three-channel build: sel=3 has no channel
      mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; in_data3 = 24'h3C_2B_1A;
      @(negedge clk);
      chk("n3_sel3_ready", 32'(in_ready3), 32'h0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("n3_sel3_out_valid", 32'(out_valid3), 32'h0);
      sel3 = 2'd2;
      #1;
      chk("n3_sel2_ready", 32'(in_ready3), 32'b100);
      @(posedge clk); #1;
      chk("n3_sel2_out", 32'({out_valid3, out_ch3, out_data3}), 32'({1'b1, 2'd2, 8'h3C}));
      // round-robin from reset pointer 2 wraps to ch0, then ch1
      mode3 = 1'b1; in_valid3 = 3'b011;
      @(posedge clk); #1;
      chk("n3_rr_wrap", 32'({out_valid3, out_ch3, out_data3}), 32'({1'b1, 2'd0, 8'h1A}));
      @(posedge clk); #1;
      chk("n3_rr_next", 32'({out_valid3, out_ch3, out_data3}), 32'({1'b1, 2'd1, 8'h2B}));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N-channel, W-bit registered stream multiplexer with valid/ready handshakes on every input and on the output.
- It is the next generation of the team's combinational 4:1 select mux.
- Two modes: explicit select (mux behaviour) and round-robin arbitration across all requesting channels.
- Sits between multiple producer streams and a single consumer. It registers the output so downstream timing is isolated.

Parameters:
- NUM_CH, 4, number of input channels (2..16).
- DATA_W, 8, data width per channel in bits (1..64).
- Derived localparam SEL_W = max(1, $clog2(NUM_CH)). It is not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset. Assertion is asynchronous; deassertion is synchronised externally.
- mode  input  1  0 = select mode, 1 = round-robin mode.
- sel  input  SEL_W  channel index used in select mode; ignored in round-robin mode.
- in_valid  input  NUM_CH  per-channel valid; bit i belongs to channel i.
- in_data  input  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- in_ready  output  NUM_CH  per-channel ready; at most one bit is high in any cycle.
- out_valid  output  1  output register holds a beat.
- out_data  output  DATA_W  registered data.
- out_ch  output  SEL_W  index of the channel that supplied out_data.
- out_ready  input  1  consumer accepts the beat.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_data=0, out_ch=0, rr_ptr=NUM_CH-1, so channel 0 has first round-robin priority. in_ready is all-zero while reset is asserted.
- load_en = !out_valid || out_ready. The output register accepts a new beat only when it is empty or is being drained in the same cycle.
- Grant (combinational, one-hot or zero):
  - mode=0: grant[sel] = in_valid[sel]. If sel >= NUM_CH (NUM_CH not a power of 2), there is no grant.
  - mode=1: the first channel with in_valid set wins, searching rr_ptr+1, rr_ptr+2, … with wrap modulo NUM_CH. If no valid, there is no grant.
- in_ready[i] = load_en && grant[i]. in_ready may depend on in_valid. in_valid must not depend on in_ready (producer rule).
- Transfer on channel i occurs when in_valid[i] && in_ready[i]. On the next clock edge: out_valid=1, out_data = channel i data, out_ch = i.
- If load_en && no grant: out_valid goes to 0 on the next edge. out_data and out_ch hold their previous values.
- If !load_en: the output register holds, out_valid stays 1, and all in_ready are 0.
- Latency: input to output is 1 cycle.
- Throughput: one beat per cycle while out_ready=1.
- Simultaneous drain and load: when out_valid=1 and out_ready=1 in the same cycle, the old beat is consumed and the new beat is loaded on that edge with no bubble.
- rr_ptr updates to the granted index only on an accepted transfer, and only in mode=1. It is unchanged in mode=0 or when there is no transfer.
- Mode or sel changes take effect in the same cycle's grant. The beat already held in the output register is unaffected.
- Wrap-around: when rr_ptr = NUM_CH-1, the search starts at channel 0.
- Reset mid-operation: any held beat is discarded, out_valid drops immediately (async), and rr_ptr returns to NUM_CH-1.
- Output stability: while out_valid=1 && out_ready=0, out_data and out_ch must not change.

Test Plan:
- Reset, then mode=0, sel=2, in_valid=4'b0100, ch2 data=0xA5, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=0xA5, out_ch=2.
- mode=0, sel=1, in_valid=4'b1101 (ch1 idle) -> in_ready=0000; out_valid=0 on the following cycle.
- mode=1, all four channels valid continuously (ch0..3 data = 0x10, 0x11, 0x12, 0x13), out_ready=1 -> out_ch sequence 0,1,2,3,0,… with matching data and one beat per cycle.
- mode=1, beat held, out_ready=0 for 3 cycles, then 1 -> in_ready=0000 and out_data stable while stalled; rr_ptr unchanged; next grant resumes after the held channel.
- mode=1, only ch3 then ch0 valid after ptr=3 -> ch0 granted (wrap); NUM_CH=3 build with mode=0, sel=3 -> no grant, out_valid=0.
- Assert rst_n=0 mid-stream with out_valid=1 -> out_valid=0 immediately, out_data=0; after release with all channels valid in mode=1, first grant goes to ch0.
